// File: rtl/serial_add16_pkg.sv
// serial_add16_pkg: FSM state encodings and default width shared with the ALU control decoder
package serial_add16_pkg;
  localparam int WIDTH_DEF = 16;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/serial_add16_if.sv
// serial_add16_if: request/result bundle of the bit-serial add/subtract unit
interface serial_add16_if #(parameter int WIDTH = serial_add16_pkg::WIDTH_DEF);
  logic start;
  logic sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic c_out;
  logic ovf;
  logic zero;
  modport master(output start, sub, a, b, input busy, done, sum, c_out, ovf, zero);
  modport slave(input start, sub, a, b, output busy, done, sum, c_out, ovf, zero);
endinterface

// File: rtl/Add_Full.sv
// Add_Full: 1-bit full adder cell
module Add_Full (
  output logic sum,
  output logic c_out,
  input  logic a,
  input  logic b,
  input  logic c_in
);
  assign sum = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/serial_add16.sv
// serial_add16: bit-serial add/subtract through one full adder cell, registered result and flags
module serial_add16 import serial_add16_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic rst,
  serial_add16_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  logic [1:0] state;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0] cnt;
  logic carry, c_msb_in, s_bit, c_bit, accept;
  Add_Full u_fa (.sum(s_bit), .c_out(c_bit), .a(a_sh[0]), .b(b_sh[0]), .c_in(carry));
  assign accept = bus.start && state != ST_SHIFT;
  // busy/done and the result lag the state by one edge so every output is a plain register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sh <= '0;
      b_sh <= '0;
      res <= '0;
      cnt <= '0;
      carry <= 1'b0;
      c_msb_in <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum <= '0;
      bus.c_out <= 1'b0;
      bus.ovf <= 1'b0;
      bus.zero <= 1'b0;
    end else begin
      bus.busy <= state == ST_SHIFT;
      bus.done <= state == ST_DONE;
      if (state == ST_DONE) begin
        bus.sum <= res;
        bus.c_out <= carry;
        bus.ovf <= c_msb_in ^ carry;
        bus.zero <= res == '0;
      end
      if (accept) begin
        a_sh <= bus.a;
        b_sh <= bus.sub ? ~bus.b : bus.b;
        carry <= bus.sub;
        cnt <= '0;
        state <= ST_SHIFT;
      end else if (state == ST_SHIFT) begin
        res <= {s_bit, res[WIDTH-1:1]};
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        carry <= c_bit;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 2)) c_msb_in <= c_bit;
        if (cnt == CW'(WIDTH - 1)) state <= ST_DONE;
      end else begin
        state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_add16.sv
// tb_serial_add16: directed and random operations checked against an arithmetic reference model
module tb_serial_add16;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] prev_sum = '0;
  serial_add16_if #(.WIDTH(W)) bus();
  serial_add16 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // {c_out, ovf, zero, sum} from plain integer arithmetic
  function automatic logic [W+2:0] model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    int ua = int'(av);
    int ub = int'(bv);
    int sa = int'($signed(av));
    int sb = int'($signed(bv));
    int ru = sv ? ua - ub : ua + ub;
    int rs = sv ? sa - sb : sa + sb;
    logic [W-1:0] s = W'(ru);
    logic c = sv ? (ua >= ub) : (ru >= (1 << W));
    logic v = (rs >= (1 << (W - 1))) || (rs < -(1 << (W - 1)));
    return {c, v, s == '0, s};
  endfunction
  task automatic check_result(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    logic [W+2:0] e = model(av, bv, sv);
    check({tag, "/sum"}, 32'(bus.sum), 32'(e[W-1:0]));
    check({tag, "/c_out"}, 32'(bus.c_out), 32'(e[W+2]));
    check({tag, "/ovf"}, 32'(bus.ovf), 32'(e[W+1]));
    check({tag, "/zero"}, 32'(bus.zero), 32'(e[W]));
    prev_sum = e[W-1:0];
  endtask
  // pa/pb: busy cycles that pulse a stray start; ra: busy cycle that raises rst (-1 = none)
  task automatic op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                    input int pa, input int pb, input int ra);
    int ndone = 0;
    int lat = 0;
    bus.a = av;
    bus.b = bv;
    bus.sub = sv;
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= W + 8; n++) begin
      bus.start = (n - 1 == pa) || (n - 1 == pb);
      if (bus.start) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.sub = 1'($urandom);
      end
      rst = (n - 1 == ra);
      @(posedge clk); #1;
      if (n - 1 == ra) begin
        check({tag, "/rst_clear"}, 32'({bus.busy, bus.done, bus.c_out, bus.ovf, bus.zero, bus.sum}), 32'd0);
        prev_sum = '0;
      end
      if (n == 1) check({tag, "/busy_first"}, 32'(bus.busy), 32'd1);
      if (n == 5) check({tag, "/sum_hold"}, 32'(bus.sum), 32'(prev_sum));
      if (bus.done) begin
        ndone++;
        if (lat == 0) begin
          lat = n;
          check({tag, "/busy_at_done"}, 32'(bus.busy), 32'd0);
          check_result(tag, av, bv, sv);
        end
      end
    end
    rst = 1'b0;
    bus.start = 1'b0;
    check({tag, "/done_pulses"}, 32'(ndone), ra >= 0 ? 32'd0 : 32'd1);
    if (ra < 0) check({tag, "/latency"}, 32'(lat), 32'(W + 1));
  endtask
  task automatic b2b(input int k);
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic qs[$];
    for (int i = 0; i < k; i++) begin
      qa.push_back(W'($urandom));
      qb.push_back(W'($urandom));
      qs.push_back(1'($urandom));
    end
    bus.a = qa[0];
    bus.b = qb[0];
    bus.sub = qs[0];
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < k; i++) begin
      if (i + 1 < k) begin
        bus.a = qa[i+1];
        bus.b = qb[i+1];
        bus.sub = qs[i+1];
      end else begin
        bus.start = 1'b0;
      end
      for (int n = 1; n <= W + 1; n++) begin
        @(posedge clk); #1;
        if (n == 8) check("b2b/sum_hold", 32'(bus.sum), 32'(prev_sum));
        if (n == W) check("b2b/no_early_done", 32'(bus.done), 32'd0);
        if (n == W + 1) begin
          check("b2b/done", 32'(bus.done), 32'd1);
          check_result("b2b", qa[i], qb[i], qs[i]);
        end
      end
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.sub = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({bus.busy, bus.done, bus.c_out, bus.ovf, bus.zero, bus.sum}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(bus.busy), 32'd0);
    op("add_5555", 16'h1234, 16'h4321, 1'b0, -1, -1, -1);
    op("add_carry", 16'hFFFF, 16'h0001, 1'b0, -1, -1, -1);
    op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, -1, -1, -1);
    op("sub_borrow", 16'h0005, 16'h0007, 1'b1, -1, -1, -1);
    op("sub_ovf", 16'h8000, 16'h0001, 1'b1, -1, -1, -1);
    op("stray_start", 16'h0F0F, 16'h00F1, 1'b0, 3, 10, -1);
    op("rst_mid", 16'hABCD, 16'h1111, 1'b0, -1, -1, 8);
    op("after_rst", 16'h0001, 16'h0001, 1'b0, -1, -1, -1);
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("rst_priority", 32'({bus.busy, bus.done}), 32'd0);
    prev_sum = '0;
    repeat (20) op("random", W'($urandom), W'($urandom), 1'($urandom), -1, -1, -1);
    b2b(6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
